// File: rtl/core_seq_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StTrap
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ILLEGAL  = 2'b01,
    FETCH_TO = 2'b10,
    DATA_TO  = 2'b11
  } trap_cause_t;

  localparam int unsigned PerfCntWidth = 32;

  // Counter width for a timeout limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ack_timeout_counter.sv
// Counts consecutive request cycles without an ack and flags the cycle in which
// the limit would be reached. An ACK_TIMEOUT of 0 never expires.
module ack_timeout_counter
  import core_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CntW = cnt_width(ACK_TIMEOUT);
  localparam logic [CntW-1:0] Limit = CntW'(ACK_TIMEOUT);

  logic [CntW-1:0] cnt_q;

  // Saturating wait counter; an accepted ack restarts it for the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || ack) begin
      cnt_q <= '0;
    end else if (count_en && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  if (ACK_TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    // Final allowed cycle without ack; an ack in that same cycle wins.
    assign expired = count_en & ~ack & (cnt_q == Limit - CntW'(1));
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with ack timeout trap.
// Optional feature macro: SEQ_PERF_COUNTERS_EN adds instr_retired and stall_cycles.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_ack,
  input  logic                    data_ack,
  input  logic                    write,
  input  logic                    load,
  input  logic                    store,
  input  logic                    branch,
  input  logic                    illegal,
  output logic                    instr_req,
  output logic                    ir_en,
  output logic                    data_req,
  output logic                    data_we,
  output logic                    reg_write_en,
  output logic                    pc_en,
  output logic                    halt,
  output logic [1:0]              trap_cause
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [PerfCntWidth-1:0] instr_retired,
  output logic [PerfCntWidth-1:0] stall_cycles
`endif
);

  seq_state_t  state_q;
  trap_cause_t cause_q;
  logic        req_state;
  logic        cur_ack;
  logic        expired;

  // Branch and no-op share the same path; the flag is kept for interface completeness.
  logic unused_branch;
  assign unused_branch = branch;

  assign req_state = (state_q == StFetch) || (state_q == StMemory);
  assign cur_ack   = (state_q == StFetch) ? instr_ack :
                     (state_q == StMemory) ? data_ack : 1'b0;

  ack_timeout_counter #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~req_state),
    .count_en(req_state),
    .ack     (req_state & cur_ack),
    .expired (expired)
  );

  // State sequencing and sticky trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      cause_q <= NONE;
    end else begin
      unique case (state_q)
        StBoot: state_q <= StFetch;
        StFetch: begin
          if (instr_ack) begin
            state_q <= StDecode;
          end else if (expired) begin
            state_q <= StTrap;
            cause_q <= FETCH_TO;
          end
        end
        StDecode: begin
          if (illegal || (load && store)) begin
            state_q <= StTrap;
            cause_q <= ILLEGAL;
          end else begin
            state_q <= StExecute;
          end
        end
        StExecute: begin
          if (load || store)  state_q <= StMemory;
          else if (write)     state_q <= StWriteback;
          else                state_q <= StFetch;
        end
        StMemory: begin
          if (data_ack) begin
            state_q <= load ? StWriteback : StFetch;
          end else if (expired) begin
            state_q <= StTrap;
            cause_q <= DATA_TO;
          end
        end
        StWriteback: state_q <= StFetch;
        StTrap:      state_q <= StTrap;
        default:     state_q <= StBoot;
      endcase
    end
  end

  // Per-cycle strobes decoded from the current state and the live acks.
  always_comb begin
    instr_req    = 1'b0;
    ir_en        = 1'b0;
    data_req     = 1'b0;
    data_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_en        = 1'b0;
    halt         = 1'b0;
    unique case (state_q)
      StFetch: begin
        instr_req = 1'b1;
        ir_en     = instr_ack;
      end
      StExecute: pc_en = ~(load | store | write);
      StMemory: begin
        data_req = 1'b1;
        data_we  = store;
        pc_en    = data_ack & ~load;
      end
      StWriteback: begin
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
      end
      StTrap:  halt = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;

`ifdef SEQ_PERF_COUNTERS_EN
  logic stall;
  assign stall = req_state & ~cur_ack;

  // Retirement and stall counters; they wrap naturally and hold once trapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else if (state_q != StTrap) begin
      if (pc_en) instr_retired <= instr_retired + PerfCntWidth'(1);
      if (stall) stall_cycles  <= stall_cycles + PerfCntWidth'(1);
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: each instruction is expanded into its
// expected per-cycle output trace from its class and ack wait counts.
module tb_core_sequencer;

  localparam int TO = 4;

  localparam int KAlu     = 0;
  localparam int KLoad    = 1;
  localparam int KStore   = 2;
  localparam int KBranch  = 3;
  localparam int KNop     = 4;
  localparam int KIllegal = 5;
  localparam int KLdSt    = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_ack = 1'b0, data_ack = 1'b0;
  logic write = 1'b0, load = 1'b0, store = 1'b0, branch = 1'b0, illegal = 1'b0;
  logic instr_req, ir_en, data_req, data_we, reg_write_en, pc_en, halt;
  logic [1:0] trap_cause;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] instr_retired, stall_cycles;
`endif

  core_sequencer #(
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_ack   (instr_ack),
    .data_ack    (data_ack),
    .write       (write),
    .load        (load),
    .store       (store),
    .branch      (branch),
    .illegal     (illegal),
    .instr_req   (instr_req),
    .ir_en       (ir_en),
    .data_req    (data_req),
    .data_we     (data_we),
    .reg_write_en(reg_write_en),
    .pc_en       (pc_en),
    .halt        (halt),
    .trap_cause  (trap_cause)
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    .instr_retired(instr_retired),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // exp bits: {instr_req, ir_en, data_req, data_we, reg_write_en, pc_en, halt, cause[1:0]}
  typedef struct packed {
    logic       iack;
    logic       dack;
    logic [8:0] exp;
  } cyc_t;

  cyc_t        plan[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned m_ret = 0;
  int unsigned m_stall = 0;

  function automatic logic [8:0] outv(input bit ireq, input bit iren, input bit dreq,
                                      input bit dwe, input bit rwe, input bit pc,
                                      input bit hlt, input logic [1:0] cause);
    return {ireq, iren, dreq, dwe, rwe, pc, hlt, cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic iack, input logic dack, input logic [8:0] e);
    cyc_t c;
    c.iack = iack;
    c.dack = dack;
    c.exp  = e;
    plan.push_back(c);
  endfunction

  function automatic void add_trap(input logic [1:0] cause);
    for (int i = 0; i < 3; i++) push(rb(), rb(), outv(0, 0, 0, 0, 0, 0, 1, cause));
  endfunction

  // Expected trace of one instruction; returns 1 when it ends in a trap.
  function automatic bit build_plan(input int kind, input int fw, input int dw);
    bit st;
    plan.delete();
    if (fw >= TO) begin
      for (int i = 0; i < TO; i++) push(0, rb(), outv(1, 0, 0, 0, 0, 0, 0, 2'b00));
      add_trap(2'b10);
      return 1'b1;
    end
    for (int i = 0; i < fw; i++) push(0, rb(), outv(1, 0, 0, 0, 0, 0, 0, 2'b00));
    push(1, rb(), outv(1, 1, 0, 0, 0, 0, 0, 2'b00));
    push(rb(), rb(), '0);
    if (kind == KIllegal || kind == KLdSt) begin
      add_trap(2'b01);
      return 1'b1;
    end
    push(rb(), rb(), outv(0, 0, 0, 0, 0, (kind == KBranch || kind == KNop), 0, 2'b00));
    if (kind == KLoad || kind == KStore) begin
      st = (kind == KStore);
      if (dw >= TO) begin
        for (int i = 0; i < TO; i++) push(rb(), 0, outv(0, 0, 1, st, 0, 0, 0, 2'b00));
        add_trap(2'b11);
        return 1'b1;
      end
      for (int i = 0; i < dw; i++) push(rb(), 0, outv(0, 0, 1, st, 0, 0, 0, 2'b00));
      push(rb(), 1, outv(0, 0, 1, st, 0, st, 0, 2'b00));
    end
    if (kind == KAlu || kind == KLoad) push(rb(), rb(), outv(0, 0, 0, 0, 1, 1, 0, 2'b00));
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {instr_req, ir_en, data_req, data_we, reg_write_en, pc_en, halt, trap_cause};
  endfunction

  // Per-cycle comparison of all outputs, plus the perf counters when present.
  task automatic compare_cycle(input cyc_t c);
    check("cycle_outputs", 32'(dut_outs()), 32'(c.exp));
`ifdef SEQ_PERF_COUNTERS_EN
    check("instr_retired", instr_retired, m_ret);
    check("stall_cycles", stall_cycles, m_stall);
`endif
    if (c.exp[3]) m_ret++;
    if ((c.exp[8] && !c.iack) || (c.exp[6] && !c.dack)) m_stall++;
  endtask

  task automatic set_flags(input int kind);
    write   = (kind == KAlu) || (kind == KLoad && rb());
    load    = (kind == KLoad) || (kind == KLdSt);
    store   = (kind == KStore) || (kind == KLdSt);
    branch  = (kind == KBranch);
    illegal = (kind == KIllegal);
  endtask

  task automatic run_plan(input int kind, input int stop_at);
    for (int i = 0; i < plan.size() && i < stop_at; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) set_flags(kind);
      instr_ack = plan[i].iack;
      data_ack  = plan[i].dack;
      @(negedge clk);
      compare_cycle(plan[i]);
    end
  endtask

  task automatic run_inst(input int kind, input int fw, input int dw, output bit trapped);
    trapped = build_plan(kind, fw, dw);
    run_plan(kind, 1 << 30);
  endtask

  // Asynchronous reset asserted mid-cycle, then one BOOT cycle after release.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero", 32'(dut_outs()), 32'd0);
`ifdef SEQ_PERF_COUNTERS_EN
    check("reset_retired_zero", instr_retired, 32'd0);
    check("reset_stall_zero", stall_cycles, 32'd0);
`endif
    m_ret   = 0;
    m_stall = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    instr_ack = rb();
    data_ack  = rb();
    @(negedge clk);
    check("boot_outputs_zero", 32'(dut_outs()), 32'd0);
  endtask

  initial begin
    bit t;
    int kind, fw, dw, r, dreq_cnt;

    do_reset();

    // Hand-derived instruction shapes pin the trace builder.
    t = build_plan(KAlu, 0, 0);
    check("pin_alu_len", plan.size(), 4);
    check("pin_alu_wb", 32'(plan[3].exp), 32'(9'b000011000));
    t = build_plan(KLoad, 0, 3);
    check("pin_load_len", plan.size(), 8);
    dreq_cnt = 0;
    foreach (plan[i]) if (plan[i].exp[6]) dreq_cnt++;
    check("pin_load_dreq_cycles", dreq_cnt, 4);
    t = build_plan(KStore, 0, 0);
    check("pin_store_len", plan.size(), 4);
    check("pin_store_pc", 32'(plan[3].exp), 32'(9'b001101000));
    t = build_plan(KBranch, 0, 0);
    check("pin_branch_len", plan.size(), 3);
    check("pin_branch_pc", 32'(plan[2].exp), 32'(9'b000001000));

    // Directed instruction mix, back to back.
    run_inst(KAlu, 0, 0, t);
    run_inst(KLoad, 0, 3, t);
    run_inst(KStore, 0, 0, t);
    run_inst(KBranch, 0, 0, t);
    run_inst(KNop, 1, 0, t);
    run_inst(KLoad, TO - 1, 0, t);
    check("ack_last_cycle_no_halt", 32'(halt), 32'd0);

    run_inst(KLoad, TO, 0, t);
    check("fetch_to_halt", 32'(halt), 32'd1);
    check("fetch_to_cause", 32'(trap_cause), 32'd2);
    do_reset();

    run_inst(KIllegal, 0, 0, t);
    check("illegal_cause", 32'(trap_cause), 32'd1);
    do_reset();

    run_inst(KStore, 0, TO, t);
    check("data_to_cause", 32'(trap_cause), 32'd3);
    do_reset();

    run_inst(KStore, 0, TO - 1, t);

    // Reset while the load sits in its memory wait.
    t = build_plan(KLoad, 0, 3);
    run_plan(KLoad, 5);
    check("mid_memory_data_req", 32'(data_req), 32'd1);
    do_reset();

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      kind = KIllegal;
      else if (r == 1) kind = KLdSt;
      else             kind = r % 5;
      fw = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
      dw = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
      run_inst(kind, fw, dw, t);
      if (t) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory. It consumes the instruction-class flags from the control decoder and produces the per-cycle enables for the IR, PC, register file and data port. It traps on illegal decode or memory-ack timeout.

## Interface
- ACK_TIMEOUT, 16, max request cycles without ack before trap; 0 disables timeout
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- instr_ack  in  1  instruction memory ack; sampled only while instr_req=1
- data_ack  in  1  data memory ack; sampled only while data_req=1
- write, load, store, branch  in  1 each  decoder class flags; stable from DECODE until instruction retires
- illegal  in  1  decoder found no valid opcode
- instr_req  out  1  fetch request
- ir_en  out  1  latch instruction register
- data_req  out  1  data memory request
- data_we  out  1  data request is a store
- reg_write_en  out  1  register file write strobe
- pc_en  out  1  PC update strobe
- halt  out  1  core in TRAP
- trap_cause  out  2  00 none, 01 illegal, 10 fetch timeout, 11 data timeout

## Operation
- States: BOOT, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- Outputs are combinational from state and acks. All outputs are 0 in BOOT and during reset.
- BOOT goes to FETCH unconditionally.
- FETCH: instr_req=1. On instr_ack, ir_en=1 in the same cycle and next state is DECODE.
- DECODE: one cycle.
  - illegal=1, or load and store both 1: go to TRAP, trap_cause=01.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - load or store: go to MEMORY.
  - else write: go to WRITEBACK.
  - else: pc_en=1 and go to FETCH (branch, or no-op class).
- MEMORY: data_req=1, data_we=store.
  - On data_ack with load: go to WRITEBACK.
  - On data_ack with store: pc_en=1 and go to FETCH.
- WRITEBACK: reg_write_en=1 and pc_en=1, then go to FETCH.
- TRAP: halt=1, all strobes 0. State and trap_cause are sticky until rst_n.
- Timeout counter:
  - Clears on entry to FETCH or MEMORY.
  - Increments on each request cycle without ack.
  - If no ack arrives in ACK_TIMEOUT consecutive request cycles, go to TRAP with cause 10 (FETCH) or 11 (MEMORY).
  - Ack in the final allowed cycle wins over timeout.
  - Width is $clog2(ACK_TIMEOUT+1), and the counter saturates.

## Timing
- Zero-wait acks give these instruction lengths: R/I-ALU/U/J 4 cycles, load 5, store 4, branch 3.
- Each wait cycle on an ack adds exactly one cycle.
- ack asserted in the first request cycle is accepted in that cycle.
- An ack that arrives outside its request state is ignored.
- pc_en and reg_write_en are single-cycle pulses, and each is at most one per instruction.
- Reset asserted mid-instruction forces BOOT asynchronously and all outputs to 0. The first instr_req comes 1 cycle after rst_n deasserts.

## Configuration
- SEQ_PERF_COUNTERS_EN defined: adds two outputs.
  - instr_retired  out  32: increments on every pc_en.
  - stall_cycles  out  32: increments on every request cycle without ack.
  - Both reset to 0, wrap at 2^32, and freeze in TRAP.
- SEQ_PERF_COUNTERS_EN undefined: these ports and their logic are absent. Sequencing is identical.

## Structure
- Package core_seq_pkg holds:
  - state enum seq_state_t.
  - trap_cause_t enum with values NONE, ILLEGAL, FETCH_TO, DATA_TO.
  - Width localparam for the perf counters.
- Sub-module ack_timeout_counter takes clear, count_en and ack, and produces expired. It is instantiated once and shared by FETCH and MEMORY.

## Test plan
- ALU instruction (write=1), instr_ack and data_ack tied 1 -> reg_write_en and pc_en pulse together in cycle 4 after FETCH entry; data_req never rises.
- Load with data_ack delayed 3 cycles -> data_req high 4 cycles with data_we=0, then WRITEBACK; instruction takes 8 cycles.
- Store, then branch back-to-back -> store pc_en in MEMORY at cycle 4, branch pc_en in EXECUTE at cycle 3; reg_write_en never rises.
- illegal=1 in DECODE -> halt=1, trap_cause=01 next cycle; further acks ignored until rst_n.
- ACK_TIMEOUT=4, instr_ack low -> TRAP after 4 request cycles with cause 10. Repeat with ack in request cycle 4 -> accepted, no trap.
- rst_n pulsed low during MEMORY -> all outputs 0 immediately; instr_req returns 1 cycle after release. With SEQ_PERF_COUNTERS_EN defined, both counters read 0.
